// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, write-to-read bypass and a busy counter.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (never busy, writes/issues dropped).
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wrLive, issueLive, incr, decr;

  // An address is live when it maps to a real, writable register.
  function automatic logic addrLive(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < LIMIT);
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0) ok = 1'b0;
`endif
    return ok;
  endfunction

  assign wrLive    = wr_en && addrLive(wr_addr);
  assign issueLive = issue_en && addrLive(issue_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wrLive) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Same-address issue and writeback leaves the bit set: the new producer wins.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    incr   = issueLive && !busy_q[issue_addr];
    decr   = wrLive && busy_q[wr_addr] && !(issueLive && (issue_addr == wr_addr));
    if (wrLive)    busy_d[wr_addr]    = 1'b0;
    if (issueLive) busy_d[issue_addr] = 1'b1;
    if (incr && !decr)      cnt_d = cnt_q + 1'b1;
    else if (decr && !incr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    if (addrLive(rd_addr1)) begin
      if (wrLive && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
      end else begin
        rd_data1 = regs_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    if (addrLive(rd_addr2)) begin
      if (wrLive && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
      end else begin
        rd_data2 = regs_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
      end
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios plus random traffic against a
// behavioural register/busy model; 12 registers behind a 4-bit address to reach out-of-range.
module tb_reg_file_sb;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 12;
  localparam int ADDR_W   = 4;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              b1;
    logic              b2;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              issue_en = 1'b0;
  logic [ADDR_W-1:0] issue_addr = '0;
  logic [ADDR_W-1:0] rd_addr1 = '0;
  logic [ADDR_W-1:0] rd_addr2 = '0;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              rd_busy1, rd_busy2;
  logic [ADDR_W:0]   busy_cnt;

  logic [DATA_W-1:0] modelMem  [2**ADDR_W];
  bit                modelBusy [2**ADDR_W];
  exp_t              expQ [$];
  int                checksTotal = 0;
  int                checksPassed = 0;

  reg_file_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit live(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  // Reference state: what the architectural registers and busy flags should hold.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        modelMem[i]  = '0;
        modelBusy[i] = 1'b0;
      end
    end else begin
      if (wr_en && live(wr_addr)) begin
        modelMem[wr_addr]  = wr_data;
        modelBusy[wr_addr] = 1'b0;
      end
      if (issue_en && live(issue_addr)) modelBusy[issue_addr] = 1'b1;
    end
  end

  task automatic predictRead(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                             output logic b);
    d = '0;
    b = 1'b0;
    if (live(a)) begin
      if (wr_en && live(wr_addr) && (wr_addr == a)) begin
        d = wr_data;
      end else begin
        d = modelMem[a];
        b = modelBusy[a];
      end
    end
  endtask

  // rstMode: 0 = run, 1 = assert reset mid-cycle, 2 = hold reset low.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic ie,
                               input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] r1,
                               input logic [ADDR_W-1:0] r2, input int rstMode);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    rst        = (rstMode == 2) ? 1'b0 : 1'b1;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    rd_addr1   = r1;
    rd_addr2   = r2;
    #2;
    if (rstMode == 1) rst = 1'b0;
    #1;
    predictRead(r1, e.d1, e.b1);
    predictRead(r2, e.d2, e.b2);
    n = 0;
    for (int i = 0; i < 2**ADDR_W; i++) n += int'(modelBusy[i]);
    e.cnt = (ADDR_W+1)'(n);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checksTotal++;
    if (act === req) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rd_data1", 32'(rd_data1), 32'(e.d1));
        checkOutput("rd_data2", 32'(rd_data2), 32'(e.d2));
        checkOutput("rd_busy1", 32'(rd_busy1), 32'(e.b1));
        checkOutput("rd_busy2", 32'(rd_busy2), 32'(e.b2));
        checkOutput("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] wa, ia;
    int mode;
    #1 rst = 1'b0;

    // Reset state across every address, including out-of-range ones.
    for (int i = 0; i < 2**ADDR_W; i += 2)
      applyStimulus(1'b0, '0, '0, 1'b0, '0, ADDR_W'(i), ADDR_W'(i + 1), 2);

    // Plain write then read, and same-cycle bypass.
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, '0, 4'd0, 4'd1, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd3, 4'd4, 0);
    applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0, '0, 4'd3, 4'd5, 0);

    // Issue then writeback releases the hazard in the writeback cycle.
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd7, 4'd7, 4'd5, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd7, 4'd5, 0);
    applyStimulus(1'b1, 4'd7, 16'h00AA, 1'b0, '0, 4'd7, 4'd3, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd7, 4'd3, 0);

    // Issue and writeback to the same busy register: busy stays, count unchanged.
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 4'd2, 4'd7, 0);
    applyStimulus(1'b1, 4'd2, 16'h0F0F, 1'b1, 4'd2, 4'd2, 4'd7, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd2, 4'd3, 0);

    // Fill the scoreboard, then reset mid-cycle with a write and issue presented.
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(i), ADDR_W'(i), 4'd3, 0);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd1, 4'd11, 4'd3, 0);
    applyStimulus(1'b1, 4'd4, 16'hDEAD, 1'b1, 4'd4, 4'd5, 4'd3, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd4, 4'd3, 2);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd4, 4'd2, 0);

    // Register 0: ordinary or hardwired depending on build.
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd1, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd0, 4'd0, 0);

    // Out-of-range write and issue are ignored.
    applyStimulus(1'b1, 4'd13, 16'h5555, 1'b1, 4'd14, 4'd13, 4'd14, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 4'd13, 4'd14, 0);

    for (int n = 0; n < 400; n++) begin
      wa   = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      ia   = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      mode = ($urandom_range(0, 63) == 0) ? 1 : 0;
      if (mode == 1)
        applyStimulus(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ia,
                      wa + 4'd1, wa + 4'd2, 1);
      else
        applyStimulus(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ia,
                      ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, 2**ADDR_W - 1)),
                      ADDR_W'($urandom_range(0, 2**ADDR_W - 1)), 0);
    end

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
